// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: a - b - bin, one bit per clock, LSB first,
// using one full-subtractor cell, a borrow flop and an IDLE/RUN/DONE handshake FSM.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             SUB_start,
  input  logic [WIDTH-1:0] SUB_a,
  input  logic [WIDTH-1:0] SUB_b,
  input  logic             SUB_bin,
  output logic             SUB_busy,
  output logic             SUB_done,
  output logic [WIDTH-1:0] SUB_diff,
  output logic             SUB_bout,
  output logic             SUB_ovf
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sr;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;

  logic             w_d;
  logic             w_br_nxt;
  logic             w_last;
  logic [WIDTH-1:0] w_sr_nxt;

  assign w_d      = r_a[0] ^ r_b[0] ^ r_br;
  assign w_br_nxt = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
  assign w_last   = (r_cnt == CW'(WIDTH-1));
  assign w_sr_nxt = {w_d, r_sr[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sr    <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (SUB_start) begin
            r_a     <= SUB_a;
            r_b     <= SUB_b;
            r_sr    <= '0;
            r_br    <= SUB_bin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_a  <= r_a >> 1;
          r_b  <= r_b >> 1;
          r_sr <= w_sr_nxt;
          r_br <= w_br_nxt;
          if (w_last) begin
            // On the final step r_a[0]/r_b[0] hold the captured operand MSBs.
            r_diff  <= w_sr_nxt;
            r_bout  <= w_br_nxt;
            r_ovf   <= (r_a[0] != r_b[0]) & (w_d != r_a[0]);
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign SUB_busy = r_busy;
  assign SUB_done = r_done;
  assign SUB_diff = r_diff;
  assign SUB_bout = r_bout;
  assign SUB_ovf  = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized self-checking bench for serial_subtractor against an integer a-b-bin model.
module tb_serial_subtractor;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         SUB_start = 1'b0;
  logic [W-1:0] SUB_a = '0;
  logic [W-1:0] SUB_b = '0;
  logic         SUB_bin = 1'b0;
  logic         SUB_busy, SUB_done, SUB_bout, SUB_ovf;
  logic [W-1:0] SUB_diff;

  int n_pass = 0;
  int n_total = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .SUB_start(SUB_start), .SUB_a(SUB_a), .SUB_b(SUB_b),
    .SUB_bin(SUB_bin), .SUB_busy(SUB_busy), .SUB_done(SUB_done), .SUB_diff(SUB_diff),
    .SUB_bout(SUB_bout), .SUB_ovf(SUB_ovf)
  );

  always #5 clk = ~clk;

  // Reference: plain unsigned and signed integer subtraction.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                                output logic [W-1:0] d, output logic bo, output logic ov);
    int r, s;
    r  = int'(a) - int'(b) - int'(bin);
    s  = int'($signed(a)) - int'($signed(b)) - int'(bin);
    d  = r[W-1:0];
    bo = (r < 0);
    ov = (s < -(2**(W-1))) || (s > (2**(W-1)) - 1);
  endfunction

  // Drive one start pulse; returns at the negedge following the accepting edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    @(negedge clk);
    SUB_a = a; SUB_b = b; SUB_bin = bin; SUB_start = 1'b1;
    @(negedge clk);
    SUB_start = 1'b0;
    SUB_a = W'($urandom); SUB_b = W'($urandom); SUB_bin = 1'($urandom);
  endtask

  // Cycles (posedges after the accepting edge) until done is seen; 20 means timeout.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (SUB_done !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    #1;
    n_total++;
    if ({SUB_busy, SUB_done, SUB_diff, SUB_bout, SUB_ovf} !== '0)
      $display("FAIL reset_state got %b required 0", {SUB_busy, SUB_done, SUB_diff, SUB_bout, SUB_ovf});
    else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed;
    logic [W-1:0] ta [5] = '{8'd100, 8'h00, 8'h05, 8'h80, 8'h7F};
    logic [W-1:0] tb [5] = '{8'd37,  8'h01, 8'h05, 8'h01, 8'hFF};
    logic         tc [5] = '{1'b0,   1'b0,  1'b1,  1'b0,  1'b0};
    logic [W-1:0] xd [5] = '{8'h3F,  8'hFF, 8'hFF, 8'h7F, 8'h80};
    logic         xb [5] = '{1'b0,   1'b1,  1'b1,  1'b0,  1'b1};
    logic         xo [5] = '{1'b0,   1'b0,  1'b0,  1'b1,  1'b1};
    int cyc;
    for (int i = 0; i < 5; i++) begin
      start_op(ta[i], tb[i], tc[i]);
      wait_done(cyc);
      n_total++;
      if (cyc !== 8) $display("FAIL latency_%0d got %0d required 8", i, cyc);
      else n_pass++;
      n_total++;
      if ({SUB_diff, SUB_bout, SUB_ovf} !== {xd[i], xb[i], xo[i]})
        $display("FAIL directed_%0d got diff=%h bout=%b ovf=%b required diff=%h bout=%b ovf=%b",
                 i, SUB_diff, SUB_bout, SUB_ovf, xd[i], xb[i], xo[i]);
      else n_pass++;
    end
  endtask

  task automatic test_ignore_start;
    int cyc;
    start_op(8'd100, 8'd37, 1'b0);
    @(negedge clk); @(negedge clk);
    SUB_a = 8'hAA; SUB_b = 8'h11; SUB_bin = 1'b1; SUB_start = 1'b1;
    @(negedge clk);
    SUB_start = 1'b0;
    wait_done(cyc);
    n_total++;
    if ({SUB_diff, SUB_bout, SUB_ovf} !== {8'h3F, 1'b0, 1'b0} || cyc !== 5)
      $display("FAIL ignore_start got diff=%h bout=%b ovf=%b cyc=%0d required diff=3f bout=0 ovf=0 cyc=5",
               SUB_diff, SUB_bout, SUB_ovf, cyc);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (SUB_done !== 1'b0 || SUB_busy !== 1'b0)
      $display("FAIL ignore_idle got done=%b busy=%b required 0 0", SUB_done, SUB_busy);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int cyc;
    logic [W-1:0] ed; logic eb, eo;
    start_op(8'h12, 8'h34, 1'b0);
    wait_done(cyc);
    model(8'h12, 8'h34, 1'b0, ed, eb, eo);
    n_total++;
    if ({SUB_diff, SUB_bout, SUB_ovf} !== {ed, eb, eo})
      $display("FAIL b2b_first got %h/%b/%b required %h/%b/%b", SUB_diff, SUB_bout, SUB_ovf, ed, eb, eo);
    else n_pass++;
    SUB_a = 8'h90; SUB_b = 8'h20; SUB_bin = 1'b1; SUB_start = 1'b1;
    @(negedge clk);
    SUB_start = 1'b0;
    cyc = 1;
    while (SUB_done !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    model(8'h90, 8'h20, 1'b1, ed, eb, eo);
    n_total++;
    if (cyc !== 9) $display("FAIL b2b_spacing got %0d required 9", cyc);
    else n_pass++;
    n_total++;
    if ({SUB_diff, SUB_bout, SUB_ovf} !== {ed, eb, eo})
      $display("FAIL b2b_second got %h/%b/%b required %h/%b/%b", SUB_diff, SUB_bout, SUB_ovf, ed, eb, eo);
    else n_pass++;
  endtask

  task automatic test_reset_midrun;
    int dones;
    start_op(8'h80, 8'h01, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_total++;
    if ({SUB_busy, SUB_done, SUB_diff, SUB_bout, SUB_ovf} !== '0)
      $display("FAIL async_reset got %b required 0", {SUB_busy, SUB_done, SUB_diff, SUB_bout, SUB_ovf});
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (15) begin
      @(negedge clk);
      if (SUB_done === 1'b1) dones++;
    end
    n_total++;
    if (dones !== 0 || SUB_diff !== 8'h00)
      $display("FAIL reset_abort got dones=%0d diff=%h required dones=0 diff=00", dones, SUB_diff);
    else n_pass++;
  endtask

  task automatic test_random;
    logic [W-1:0] corner [5] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
    logic [W-1:0] a, b, ed;
    logic bin, eb, eo;
    int cyc, errs, extra;
    errs = 0; extra = 0;
    for (int i = 0; i < 1250; i++) begin
      if (i < 50) begin
        a = corner[i % 5]; b = corner[(i / 5) % 5]; bin = 1'(i / 25);
      end else begin
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      end
      model(a, b, bin, ed, eb, eo);
      start_op(a, b, bin);
      wait_done(cyc);
      n_total++;
      if (cyc !== 8 || {SUB_diff, SUB_bout, SUB_ovf} !== {ed, eb, eo}) begin
        errs++;
        if (errs <= 10)
          $display("FAIL random a=%h b=%h bin=%b got %h/%b/%b cyc=%0d required %h/%b/%b cyc=8",
                   a, b, bin, SUB_diff, SUB_bout, SUB_ovf, cyc, ed, eb, eo);
      end else n_pass++;
      @(negedge clk);
      if (SUB_done !== 1'b0) extra++;
    end
    n_total++;
    if (extra !== 0) $display("FAIL done_width got %0d long pulses required 0", extra);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_directed;
    test_ignore_start;
    test_back_to_back;
    test_reset_midrun;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
